// File: rtl/btn_step_gen_if.sv
// Button-step bundle: raw button in, debounced level / step strobe / step clock / count out.
interface btn_step_gen_if #(
   parameter int unsigned CNT_W = 16
);
   logic             btn;
   logic             btn_level;
   logic             step_pulse;
   logic             step_clk;
   logic [CNT_W-1:0] step_count;
   logic             busy;

   // Board side: drives the button, observes the step outputs
   modport master (
      output btn,
      input  btn_level, step_pulse, step_clk, step_count, busy
   );

   // Step generator side
   modport slave (
      input  btn,
      output btn_level, step_pulse, step_clk, step_count, busy
   );
endinterface

// File: rtl/btn_step_gen.sv
// Push-button to single-step clock: 2-flop sync, debounce, press detect and a
// fixed-width step_clk pulse per press.
// Optional auto-repeat while held: define BTN_STEP_AUTOREPEAT_EN.
module btn_step_gen #(
   parameter int unsigned DEBOUNCE_CYCLES  = 1000000,
   parameter int unsigned STEP_HIGH_CYCLES = 8,
   parameter int unsigned CNT_W            = 16
`ifdef BTN_STEP_AUTOREPEAT_EN
   ,
   parameter int unsigned REPEAT_DELAY     = 50000000,
   parameter int unsigned REPEAT_PERIOD    = 10000000
`endif
) (
   input logic           clk_100MHz,
   input logic           rst,
   btn_step_gen_if.slave bus
);

   localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned HI_W = (STEP_HIGH_CYCLES > 1) ? $clog2(STEP_HIGH_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HI_W-1:0] HI_LOAD = HI_W'(STEP_HIGH_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, HIGH, WAIT_REL} state_t;

   logic [1:0]       sync_q;
   logic             btn_s;
   logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
   logic             btn_level_q, btn_level_d;
   logic             btn_level_dly_q;
   logic             rise;
   state_t           state_q, state_d;
   logic [HI_W-1:0]  hcnt_q, hcnt_d;
   logic             step_pulse_q, step_pulse_d;
   logic             step_clk_q, step_clk_d;
   logic [CNT_W-1:0] step_count_q, step_count_d;

`ifdef BTN_STEP_AUTOREPEAT_EN
   localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned REP_W   = $clog2(REP_MAX) + 1;

   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
   logic             rep_first_q, rep_first_d;
   logic [REP_W-1:0] rep_limit;
   logic             rep_fire;

   // Repeat interval is measured from the start of the previous step
   assign rep_limit = rep_first_q ? REP_W'(REPEAT_DELAY - 1) : REP_W'(REPEAT_PERIOD - 1);
   assign rep_fire  = (state_q == WAIT_REL) && btn_level_q && (rep_cnt_q >= rep_limit);
`endif

   assign btn_s = sync_q[1];
   assign rise  = btn_level_q & ~btn_level_dly_q;

   // Two-flop synchroniser for the asynchronous button
   always_ff @(posedge clk_100MHz or negedge rst) begin
      if (!rst) sync_q <= '0;
      else      sync_q <= {sync_q[0], bus.btn};
   end

   // Debounce: count consecutive disagreeing samples, flip level when the run is long enough
   always_comb begin
      db_cnt_d    = '0;
      btn_level_d = btn_level_q;
      if (btn_s != btn_level_q) begin
         if (db_cnt_q == DB_LAST) btn_level_d = ~btn_level_q;
         else                     db_cnt_d    = db_cnt_q + DB_W'(1);
      end
   end

   // Debounce state and delayed level for edge detection
   always_ff @(posedge clk_100MHz or negedge rst) begin
      if (!rst) begin
         db_cnt_q        <= '0;
         btn_level_q     <= 1'b0;
         btn_level_dly_q <= 1'b0;
      end else begin
         db_cnt_q        <= db_cnt_d;
         btn_level_q     <= btn_level_d;
         btn_level_dly_q <= btn_level_q;
      end
   end

   // Step FSM next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      hcnt_d       = hcnt_q;
      step_pulse_d = 1'b0;
      step_count_d = step_count_q;
      step_clk_d   = (state_q == HIGH);
`ifdef BTN_STEP_AUTOREPEAT_EN
      rep_first_d  = rep_first_q;
      rep_cnt_d    = (rep_cnt_q == '1) ? rep_cnt_q : rep_cnt_q + REP_W'(1);
      if (!btn_level_q) begin
         rep_cnt_d   = '0;
         rep_first_d = 1'b1;
      end
`endif
      unique case (state_q)
         IDLE: begin
            if (rise) begin
               state_d      = HIGH;
               step_pulse_d = 1'b1;
               step_count_d = step_count_q + CNT_W'(1);
               hcnt_d       = HI_LOAD;
`ifdef BTN_STEP_AUTOREPEAT_EN
               rep_cnt_d    = '0;
`endif
            end
         end
         HIGH: begin
            if (hcnt_q == '0) state_d = WAIT_REL;
            else              hcnt_d  = hcnt_q - HI_W'(1);
         end
         WAIT_REL: begin
            if (!btn_level_q) begin
               state_d = IDLE;
            end
`ifdef BTN_STEP_AUTOREPEAT_EN
            else if (rep_fire) begin
               state_d      = HIGH;
               step_pulse_d = 1'b1;
               step_count_d = step_count_q + CNT_W'(1);
               hcnt_d       = HI_LOAD;
               rep_cnt_d    = '0;
               rep_first_d  = 1'b0;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // Step FSM state and output registers
   always_ff @(posedge clk_100MHz or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         hcnt_q       <= '0;
         step_pulse_q <= 1'b0;
         step_clk_q   <= 1'b0;
         step_count_q <= '0;
      end else begin
         state_q      <= state_d;
         hcnt_q       <= hcnt_d;
         step_pulse_q <= step_pulse_d;
         step_clk_q   <= step_clk_d;
         step_count_q <= step_count_d;
      end
   end

`ifdef BTN_STEP_AUTOREPEAT_EN
   // Auto-repeat interval counter
   always_ff @(posedge clk_100MHz or negedge rst) begin
      if (!rst) begin
         rep_cnt_q   <= '0;
         rep_first_q <= 1'b1;
      end else begin
         rep_cnt_q   <= rep_cnt_d;
         rep_first_q <= rep_first_d;
      end
   end
`endif

   assign bus.btn_level  = btn_level_q;
   assign bus.step_pulse = step_pulse_q;
   assign bus.step_clk   = step_clk_q;
   assign bus.busy       = step_clk_q;
   assign bus.step_count = step_count_q;

endmodule

// File: tb/tb_btn_step_gen.sv
// Bench for btn_step_gen: directed presses with a pulse scoreboard and step_clk monitor.
module tb_btn_step_gen;
   localparam int unsigned DB = 4;
   localparam int unsigned SH = 3;
   localparam int unsigned CW = 2;

   typedef struct {
      int            cyc;
      logic [CW-1:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t expq[$];

   int   hi_len = 0;
   logic prev_clk = 1'b0;
   logic prev_pulse = 1'b0;

   btn_step_gen_if #(.CNT_W(CW)) bif ();

   btn_step_gen #(
      .DEBOUNCE_CYCLES (DB),
      .STEP_HIGH_CYCLES(SH),
      .CNT_W           (CW)
   ) dut (
      .clk_100MHz(clk),
      .rst       (rst),
      .bus       (bif.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Clean press: level checked around its expected rise, then held and released
   task automatic press(input int hold, input logic [CW-1:0] cnt);
      int c;
      c = cyc;
      bif.btn = 1'b1;
      expq.push_back('{c + 7, cnt});
      tick(5);
      check("level_before_debounce", int'(bif.btn_level), 0);
      tick(1);
      check("level_after_debounce", int'(bif.btn_level), 1);
      tick(hold - 6);
      bif.btn = 1'b0;
      tick(15);
   endtask

   // Monitor: pops the scoreboard on each step_pulse and checks step_clk shape
   always @(negedge clk) begin
      if (!rst) begin
         hi_len     = 0;
         prev_clk   = 1'b0;
         prev_pulse = 1'b0;
      end else begin
         if (bif.step_pulse) begin
            if (expq.size() == 0) begin
               check("pulse_expected", 0, 1);
            end else begin
               exp_t e;
               e = expq.pop_front();
               check("pulse_cycle", cyc, e.cyc);
               check("pulse_count", int'(bif.step_count), int'(e.cnt));
            end
         end
         check("busy_eq_step_clk", int'(bif.busy), int'(bif.step_clk));
         if (bif.step_clk && !prev_clk) check("step_clk_after_pulse", int'(prev_pulse), 1);
         if (bif.step_clk) begin
            hi_len++;
         end else if (prev_clk) begin
            check("step_clk_width", hi_len, SH);
            hi_len = 0;
         end
         prev_clk   = bif.step_clk;
         prev_pulse = bif.step_pulse;
      end
   end

   initial begin
      int c;
      int budget;

      // Reset held with the button pressed
      bif.btn = 1'b1;
      rst     = 1'b0;
      tick(10);
      check("rst_btn_level", int'(bif.btn_level), 0);
      check("rst_step_pulse", int'(bif.step_pulse), 0);
      check("rst_step_clk", int'(bif.step_clk), 0);
      check("rst_step_count", int'(bif.step_count), 0);
      check("rst_busy", int'(bif.busy), 0);
      rst = 1'b1;
      c   = cyc;
      expq.push_back('{c + 7, CW'(1)});
      tick(5);
      check("rst_rel_level_early", int'(bif.btn_level), 0);
      tick(1);
      check("rst_rel_level", int'(bif.btn_level), 1);
      tick(10);
      bif.btn = 1'b0;
      tick(15);

      // Clean press
      press(20, CW'(2));

      // Bounce: 2-cycle glitches must not move the level
      for (int i = 0; i < 4; i++) begin
         bif.btn = (i % 2 == 0);
         tick(1);
         check("bounce_level", int'(bif.btn_level), 0);
         tick(1);
         check("bounce_level", int'(bif.btn_level), 0);
      end
      press(20, CW'(3));

      // Release during the first step_clk cycle
      c       = cyc;
      bif.btn = 1'b1;
      expq.push_back('{c + 7, CW'(0)});
      tick(8);
      check("rel_high_clk_first", int'(bif.step_clk), 1);
      bif.btn = 1'b0;
      tick(2);
      check("rel_high_clk_last", int'(bif.step_clk), 1);
      tick(1);
      check("rel_high_clk_done", int'(bif.step_clk), 0);
      tick(20);
      check("rel_high_level", int'(bif.btn_level), 0);

      // Fifth press completes the wrap sequence 1,2,3,0,1
      press(20, CW'(1));

      // Reset in the second step_clk cycle
      c       = cyc;
      bif.btn = 1'b1;
      expq.push_back('{c + 7, CW'(2)});
      tick(9);
      check("midrst_clk_before", int'(bif.step_clk), 1);
      rst = 1'b0;
      #1;
      check("midrst_step_clk", int'(bif.step_clk), 0);
      check("midrst_busy", int'(bif.busy), 0);
      check("midrst_step_count", int'(bif.step_count), 0);
      check("midrst_btn_level", int'(bif.btn_level), 0);
      bif.btn = 1'b0;
      tick(3);
      rst = 1'b1;
      tick(20);
      check("midrst_count_after", int'(bif.step_count), 0);

      budget = 50;
      while (expq.size() != 0 && budget > 0) begin
         tick(1);
         budget--;
      end
      check("scoreboard_drained", expq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
